// File: rtl/kalman_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kalman_pkg
//  Description : Shared types and constants for the Kalman step sequencer.
//                Defines the sequencer state encoding, the step-number type
//                and the fixed-point defaults for the R_angle constant.
//  Revision    : 1.0  initial release
// ============================================================================
package kalman_pkg;

    localparam int KALMAN_FRAC_BITS = 13;
    localparam int KALMAN_DATA_W    = 23;

    // 250 * 2^-13 ~= 0.03
    localparam logic [KALMAN_DATA_W-1:0] R_ANGLE_DEFAULT = 23'd250;

    typedef logic [2:0] step_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } kalman_state_e;

endpackage
`default_nettype wire

// File: rtl/kalman_step_timer.sv
`default_nettype none
// ============================================================================
//  Module      : kalman_step_timer
//  Description : Clear/enable counter that saturates at TIMEOUT-1 and flags
//                when that value is reached. Used to bound the wait for
//                step_done.
//  Ports       : clk, n_rst (async active-low), clr (sync clear, wins over
//                en), en (count enable), timeout (count == TIMEOUT-1)
//  Revision    : 1.0  initial release
// ============================================================================
module kalman_step_timer #(
    parameter int TIMEOUT = 16
)(
    input  logic clk,
    input  logic n_rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int                  c_cnt_w = $clog2(TIMEOUT);
    localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Saturates at c_last so a stuck datapath never wraps the count.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != c_last)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign timeout = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/kalman_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : kalman_step_sequencer
//  Description : Runs Kalman ALU steps 1..NUM_STEPS once per accepted sample.
//                Issues step_start/step_sel, waits (bounded) for step_done,
//                pulses a one-hot capture enable per finished step, then
//                presents est_valid until est_ready. A step timeout parks
//                the sequencer in an error state until err_clr.
//  Ports       : clk, n_rst (async active-low)
//                sample_valid/sample_ready  sample handshake (IDLE only)
//                step_start/step_sel/step_done  step datapath control
//                cap_en      one-hot latch enable, bit k-1 for step k
//                r_angle     R_angle constant for step 4
//                est_valid/est_ready  estimate handshake
//                busy, err (sticky), err_clr
//  Config      : KALMAN_R_ANGLE_PROG_EN adds r_angle_we/r_angle_wdata so
//                R_angle can be written while idle.
//  Revision    : 1.0  initial release
// ============================================================================
module kalman_step_sequencer
    import kalman_pkg::*;
#(
    parameter int                NUM_STEPS   = 7,
    parameter int                DATA_W      = KALMAN_DATA_W,
    parameter int                TIMEOUT     = 16,
    parameter logic [DATA_W-1:0] R_ANGLE_DEF = DATA_W'(R_ANGLE_DEFAULT)
)(
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    output logic                 step_start,
    output logic [2:0]           step_sel,
    input  logic                 step_done,
    output logic [NUM_STEPS-1:0] cap_en,
    output logic [DATA_W-1:0]    r_angle,
    output logic                 est_valid,
    input  logic                 est_ready,
    output logic                 busy,
    output logic                 err,
`ifdef KALMAN_R_ANGLE_PROG_EN
    input  logic                 r_angle_we,
    input  logic [DATA_W-1:0]    r_angle_wdata,
`endif
    input  logic                 err_clr
);

    localparam step_t                 c_first_step = step_t'(1);
    localparam step_t                 c_last_step  = step_t'(NUM_STEPS);
    localparam logic [NUM_STEPS-1:0]  c_cap_one    = NUM_STEPS'(1);

    kalman_state_e r_state;
    kalman_state_e w_state_nxt;
    step_t         r_idx;
    step_t         w_idx_nxt;
    logic          r_live;
    logic          w_timeout;

    // r_live keeps sample_ready low for the first cycle after reset release.
    assign sample_ready = (r_state == IDLE) && r_live;
    assign busy         = (r_state != IDLE);

    kalman_step_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .clr     (r_state == ISSUE),
        .en      (r_state == WAIT),
        .timeout (w_timeout)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_live  <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (sample_ready && sample_valid) begin
                    w_state_nxt = ISSUE;
                    w_idx_nxt   = c_first_step;
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                // step_done takes priority over a coincident timeout.
                if (step_done) begin
                    if (r_idx == c_last_step) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = ISSUE;
                        w_idx_nxt   = r_idx + step_t'(1);
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ERR;
                end
            end
            DONE: begin
                if (est_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            ERR: begin
                if (err_clr) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs are computed from the next state so they line up
    // with the state they describe rather than trailing it by a cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            step_start <= 1'b0;
            step_sel   <= '0;
            cap_en     <= '0;
            est_valid  <= 1'b0;
            err        <= 1'b0;
        end else begin
            step_start <= (w_state_nxt == ISSUE);
            step_sel   <= ((w_state_nxt == ISSUE) || (w_state_nxt == WAIT) ||
                           (w_state_nxt == ERR)) ? w_idx_nxt : '0;
            cap_en     <= ((r_state == WAIT) && step_done) ?
                          (c_cap_one << (r_idx - c_first_step)) : '0;
            est_valid  <= (w_state_nxt == DONE);
            err        <= (w_state_nxt == ERR);
        end
    end

`ifdef KALMAN_R_ANGLE_PROG_EN
    logic [DATA_W-1:0] r_r_angle;

    // Writes are dropped while busy so R_angle is stable for a whole sample.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_r_angle <= R_ANGLE_DEF;
        end else if (r_angle_we && !busy) begin
            r_r_angle <= r_angle_wdata;
        end
    end

    assign r_angle = r_r_angle;
`else
    assign r_angle = R_ANGLE_DEF;
`endif

endmodule
`default_nettype wire

// File: tb/tb_kalman_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kalman_step_sequencer
//  Description : Directed self-checking bench for kalman_step_sequencer.
//                Inputs change 1 time unit after the rising edge; outputs are
//                checked at that same point, away from the edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_kalman_step_sequencer;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        sample_valid;
    logic        sample_ready;
    logic        step_start;
    logic [2:0]  step_sel;
    logic        step_done;
    logic [6:0]  cap_en;
    logic [22:0] r_angle;
    logic        est_valid;
    logic        est_ready;
    logic        busy;
    logic        err;
    logic        err_clr;
`ifdef KALMAN_R_ANGLE_PROG_EN
    logic        r_angle_we;
    logic [22:0] r_angle_wdata;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    kalman_step_sequencer dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .step_start   (step_start),
        .step_sel     (step_sel),
        .step_done    (step_done),
        .cap_en       (cap_en),
        .r_angle      (r_angle),
        .est_valid    (est_valid),
        .est_ready    (est_ready),
        .busy         (busy),
        .err          (err),
`ifdef KALMAN_R_ANGLE_PROG_EN
        .r_angle_we   (r_angle_we),
        .r_angle_wdata(r_angle_wdata),
`endif
        .err_clr      (err_clr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sample_ready"}, 32'(sample_ready), 32'd0);
        chk({tag, "_step_start"},   32'(step_start),   32'd0);
        chk({tag, "_step_sel"},     32'(step_sel),     32'd0);
        chk({tag, "_cap_en"},       32'(cap_en),       32'd0);
        chk({tag, "_est_valid"},    32'(est_valid),    32'd0);
        chk({tag, "_busy"},         32'(busy),         32'd0);
        chk({tag, "_err"},          32'(err),          32'd0);
        chk({tag, "_r_angle"},      32'(r_angle),      32'd250);
    endtask

    // Called while in ISSUE for step k: one-cycle datapath answer.
    task automatic do_step(input int k);
        chk("issue_start", 32'(step_start), 32'd1);
        chk("issue_sel",   32'(step_sel),   32'(k));
        tick;
        chk("wait_start",  32'(step_start), 32'd0);
        chk("wait_sel",    32'(step_sel),   32'(k));
        chk("wait_cap",    32'(cap_en),     32'd0);
        chk("wait_estv",   32'(est_valid),  32'd0);
        step_done = 1'b1;
        tick;
        step_done = 1'b0;
        chk("cap_en",      32'(cap_en),     32'd1 << (k - 1));
        chk("cap_err",     32'(err),        32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst        = 1'b0;
        sample_valid = 1'b0;
        step_done    = 1'b0;
        est_ready    = 1'b0;
        err_clr      = 1'b0;
`ifdef KALMAN_R_ANGLE_PROG_EN
        r_angle_we    = 1'b0;
        r_angle_wdata = '0;
`endif
        #2;
        chk_reset_outputs("rst");
        tick;
        n_rst = 1'b1;
        chk("post_rst_ready0", 32'(sample_ready), 32'd0);
        tick;
        chk("post_rst_ready1", 32'(sample_ready), 32'd1);
        chk("idle_busy",       32'(busy),         32'd0);

        // ---- nominal sequence, 1-cycle datapath ----
        sample_valid = 1'b1;
        tick;
        sample_valid = 1'b0;
        chk("acc_busy",  32'(busy),         32'd1);
        chk("acc_ready", 32'(sample_ready), 32'd0);
        for (int k = 1; k <= 7; k++) begin
            do_step(k);
        end
        // 14 edges after accept
        chk("done_estv",  32'(est_valid),    32'd1);
        chk("done_sel",   32'(step_sel),     32'd0);
        chk("done_start", 32'(step_start),   32'd0);

        // ---- est_ready held low in DONE, sample_valid ignored ----
        sample_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_estv",  32'(est_valid),    32'd1);
            chk("hold_ready", 32'(sample_ready), 32'd0);
            tick;
        end
        chk("hold_start", 32'(step_start), 32'd0);
        est_ready    = 1'b1;
        sample_valid = 1'b0;
        chk("hold_estv_last", 32'(est_valid), 32'd1);
        tick;
        est_ready = 1'b0;
        chk("ret_estv",  32'(est_valid),    32'd0);
        chk("ret_ready", 32'(sample_ready), 32'd1);
        chk("ret_start", 32'(step_start),   32'd0);
        chk("ret_busy",  32'(busy),         32'd0);

        // ---- timeout during step 3 ----
        sample_valid = 1'b1;
        tick;
        sample_valid = 1'b0;
        do_step(1);
        do_step(2);
        chk("to_issue_sel", 32'(step_sel), 32'd3);
        tick;
        repeat (15) tick;
        chk("to_wait16_err", 32'(err),      32'd0);
        chk("to_wait16_sel", 32'(step_sel), 32'd3);
        tick;
        chk("to_err",       32'(err),          32'd1);
        chk("to_err_sel",   32'(step_sel),     32'd3);
        chk("to_err_busy",  32'(busy),         32'd1);
        chk("to_err_cap",   32'(cap_en),       32'd0);
        chk("to_err_ready", 32'(sample_ready), 32'd0);
        tick;
        chk("to_err_sticky", 32'(err), 32'd1);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        chk("clr_err",   32'(err),          32'd0);
        chk("clr_ready", 32'(sample_ready), 32'd1);
        chk("clr_sel",   32'(step_sel),     32'd0);

        // ---- step_done on the final timeout cycle ----
        sample_valid = 1'b1;
        tick;
        sample_valid = 1'b0;
        chk("edge_sel1", 32'(step_sel), 32'd1);
        tick;
        repeat (15) tick;
        chk("edge_wait16_err", 32'(err), 32'd0);
        step_done = 1'b1;
        tick;
        step_done = 1'b0;
        chk("edge_cap",   32'(cap_en),     32'd1);
        chk("edge_err",   32'(err),        32'd0);
        chk("edge_start", 32'(step_start), 32'd1);
        chk("edge_sel2",  32'(step_sel),   32'd2);

        // ---- reset during WAIT of step 5 ----
        do_step(2);
        do_step(3);
        do_step(4);
        chk("r5_issue_sel", 32'(step_sel), 32'd5);
        tick;
        chk("r5_wait_sel", 32'(step_sel), 32'd5);
        n_rst = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        step_done = 1'b1;
        tick;
        chk("mid_rst_cap", 32'(cap_en), 32'd0);
        step_done = 1'b0;
        n_rst     = 1'b1;
        chk("mid_rel_ready0", 32'(sample_ready), 32'd0);
        tick;
        chk("mid_rel_ready1", 32'(sample_ready), 32'd1);
        chk("mid_rel_cap",    32'(cap_en),       32'd0);
        chk("mid_rel_sel",    32'(step_sel),     32'd0);

`ifdef KALMAN_R_ANGLE_PROG_EN
        // ---- programmable R_angle ----
        chk("ra_default", 32'(r_angle), 32'd250);
        r_angle_we    = 1'b1;
        r_angle_wdata = 23'd500;
        tick;
        r_angle_we = 1'b0;
        chk("ra_write_idle", 32'(r_angle), 32'd500);
        sample_valid = 1'b1;
        tick;
        sample_valid  = 1'b0;
        r_angle_we    = 1'b1;
        r_angle_wdata = 23'd100;
        tick;
        r_angle_we = 1'b0;
        chk("ra_write_busy", 32'(r_angle), 32'd500);
        tick;
        chk("ra_write_busy2", 32'(r_angle), 32'd500);
`else
        chk("ra_const", 32'(r_angle), 32'd250);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
